// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard/stall controller: FSM state encoding,
// register-file address width and the per-stage hold mask.
package hazard_ctrl_pkg;

  localparam int RegFileAddrW = 5;

  typedef enum logic [1:0] {
    HC_RUN      = 2'd0,
    HC_MEM_WAIT = 2'd1,
    HC_MD_WAIT  = 2'd2
  } hcState_t;

  // One hold bit per pipeline register, PC first, MEM/WB last.
  typedef struct packed {
    logic pc;
    logic ifId;
    logic idEx;
    logic exMem;
    logic memWb;
  } stageMask_t;

  // A data-memory wait freezes everything. A mul/div wait lets MEM/WB drain.
  localparam stageMask_t StallAll = stageMask_t'(5'b11111);
  localparam stageMask_t StallMd  = stageMask_t'(5'b11110);

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: a load in EX whose destination is read by the
// instruction in ID. Kept separate so the decoder can reuse it.
module hazard_detect
  import hazard_ctrl_pkg::*;
#(
  parameter int RegAddrW = RegFileAddrW
) (
  input  logic [RegAddrW-1:0] rs1Addr,
  input  logic [RegAddrW-1:0] rs2Addr,
  input  logic                rs1En,
  input  logic                rs2En,
  input  logic [RegAddrW-1:0] rdAddr,
  input  logic                memRead,
  output logic                loadUse
);

  // x0 is never a real dependency, so a load into x0 does not stall.
  always_comb begin
    loadUse = memRead && (rdAddr != '0) &&
              ((rs1En && (rs1Addr == rdAddr)) || (rs2En && (rs2Addr == rdAddr)));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller: load-use, multi-cycle memory,
// multi-cycle mul/div and taken-branch redirects, with a redirect that
// survives stalls, a memory-timeout flag and a stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int          CntWidth   = 32,
  parameter int unsigned MemTimeout = 255,
  parameter int          RegAddrW   = RegFileAddrW
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [RegAddrW-1:0] Rs1AddrIdIn,
  input  logic [RegAddrW-1:0] Rs2AddrIdIn,
  input  logic                Rs1ReadEnableIdIn,
  input  logic                Rs2ReadEnableIdIn,
  input  logic [RegAddrW-1:0] RdAddrExIn,
  input  logic                MemReadExIn,
  input  logic                MulDivStartExIn,
  input  logic                MulDivDoneIn,
  input  logic                DataReqMemIn,
  input  logic                DataReadyMemIn,
  input  logic                BranchTakenExIn,
  output logic                StallPcOut,
  output logic                StallIfIdOut,
  output logic                StallIdExOut,
  output logic                StallExMemOut,
  output logic                StallMemWbOut,
  output logic                FlushIfIdOut,
  output logic                FlushIdExOut,
  output logic                RedirectOut,
  output logic [CntWidth-1:0] StallCntOut,
  output logic                ErrorOut
);

  // Wide enough to hold MemTimeout itself; the counter parks there.
  localparam int             ToW   = $clog2(MemTimeout + 2);
  localparam logic [ToW-1:0] ToMax = ToW'(MemTimeout);

  hcState_t       state, stateNext;
  logic           redirectPending, redirectPendingNext;
  logic [ToW-1:0] timeoutCnt, timeoutCntNext;
  logic           setError;
  stageMask_t     stall;
  logic           flushIfId, flushIdEx, redirect;
  logic           loadUse, memCause, mdCause;

  hazard_detect #(.RegAddrW(RegAddrW)) uDetect (
    .rs1Addr (Rs1AddrIdIn),
    .rs2Addr (Rs2AddrIdIn),
    .rs1En   (Rs1ReadEnableIdIn),
    .rs2En   (Rs2ReadEnableIdIn),
    .rdAddr  (RdAddrExIn),
    .memRead (MemReadExIn),
    .loadUse (loadUse)
  );

  // A same-cycle acknowledge means the access finished without waiting.
  assign memCause = DataReqMemIn && !DataReadyMemIn;
  assign mdCause  = MulDivStartExIn && !MulDivDoneIn;

  // Next-state and same-cycle stall/flush/redirect decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned and no latch is inferred.
    stateNext           = state;
    redirectPendingNext = redirectPending;
    timeoutCntNext      = timeoutCnt;
    setError            = 1'b0;
    stall               = '0;
    flushIfId           = 1'b0;
    flushIdEx           = 1'b0;
    redirect            = 1'b0;
    unique case (state)
      HC_RUN: begin
        if (memCause) begin
          stall     = StallAll;
          stateNext = HC_MEM_WAIT;
          if (BranchTakenExIn) redirectPendingNext = 1'b1;
        end else if (mdCause) begin
          stall     = StallMd;
          stateNext = HC_MD_WAIT;
          if (BranchTakenExIn) redirectPendingNext = 1'b1;
        end else if (redirectPending || BranchTakenExIn) begin
          // The flush of ID/EX also discards any load-use consumer.
          redirect            = 1'b1;
          flushIfId           = 1'b1;
          flushIdEx           = 1'b1;
          redirectPendingNext = 1'b0;
        end else if (loadUse) begin
          stall.pc   = 1'b1;
          stall.ifId = 1'b1;
          flushIdEx  = 1'b1;
        end
      end
      HC_MEM_WAIT: begin
        if (DataReadyMemIn) begin
          stateNext      = HC_RUN;
          timeoutCntNext = '0;
        end else begin
          stall = StallAll;
          if (timeoutCnt != ToMax) timeoutCntNext = timeoutCnt + ToW'(1);
          if ((MemTimeout != 0) && (timeoutCntNext == ToMax)) setError = 1'b1;
        end
      end
      HC_MD_WAIT: begin
        if (MulDivDoneIn) stateNext = HC_RUN;
        else              stall     = StallMd;
      end
      default: stateNext = HC_RUN;
    endcase
  end

  // Strobes are forced low during reset; a flush overrides a hold on the same register.
  always_comb begin
    StallPcOut    = !Rst && stall.pc;
    StallIfIdOut  = !Rst && stall.ifId && !flushIfId;
    StallIdExOut  = !Rst && stall.idEx && !flushIdEx;
    StallExMemOut = !Rst && stall.exMem;
    StallMemWbOut = !Rst && stall.memWb;
    FlushIfIdOut  = !Rst && flushIfId;
    FlushIdExOut  = !Rst && flushIdEx;
    RedirectOut   = !Rst && redirect;
  end

  // State, pending redirect, timeout, sticky error and saturating stall count.
  always_ff @(posedge Clk or posedge Rst) begin
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    if (Rst) begin
      state           <= HC_RUN;
      redirectPending <= 1'b0;
      timeoutCnt      <= '0;
      ErrorOut        <= 1'b0;
      StallCntOut     <= '0;
    end else begin
      state           <= stateNext;
      redirectPending <= redirectPendingNext;
      timeoutCnt      <= timeoutCntNext;
      if (setError) ErrorOut <= 1'b1;
      if (StallPcOut && (StallCntOut != '1)) StallCntOut <= StallCntOut + CntWidth'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed test-plan sequences followed by random traffic, all checked
// cycle by cycle against a behavioural model of the stall rules.
module tb_hazard_ctrl;

  localparam int CW   = 4;
  localparam int TO   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [4:0]    Rs1AddrIdIn, Rs2AddrIdIn, RdAddrExIn;
  logic          Rs1ReadEnableIdIn, Rs2ReadEnableIdIn, MemReadExIn;
  logic          MulDivStartExIn, MulDivDoneIn, DataReqMemIn, DataReadyMemIn, BranchTakenExIn;
  logic          StallPcOut, StallIfIdOut, StallIdExOut, StallExMemOut, StallMemWbOut;
  logic          FlushIfIdOut, FlushIdExOut, RedirectOut, ErrorOut;
  logic [CW-1:0] StallCntOut;
  logic [7:0]    obsO;

  always #5 Clk = ~Clk;

  hazard_ctrl #(.CntWidth(CW), .MemTimeout(TO), .RegAddrW(5)) dut (
    .Clk(Clk), .Rst(Rst),
    .Rs1AddrIdIn(Rs1AddrIdIn), .Rs2AddrIdIn(Rs2AddrIdIn),
    .Rs1ReadEnableIdIn(Rs1ReadEnableIdIn), .Rs2ReadEnableIdIn(Rs2ReadEnableIdIn),
    .RdAddrExIn(RdAddrExIn), .MemReadExIn(MemReadExIn),
    .MulDivStartExIn(MulDivStartExIn), .MulDivDoneIn(MulDivDoneIn),
    .DataReqMemIn(DataReqMemIn), .DataReadyMemIn(DataReadyMemIn),
    .BranchTakenExIn(BranchTakenExIn),
    .StallPcOut(StallPcOut), .StallIfIdOut(StallIfIdOut), .StallIdExOut(StallIdExOut),
    .StallExMemOut(StallExMemOut), .StallMemWbOut(StallMemWbOut),
    .FlushIfIdOut(FlushIfIdOut), .FlushIdExOut(FlushIdExOut),
    .RedirectOut(RedirectOut), .StallCntOut(StallCntOut), .ErrorOut(ErrorOut)
  );

  assign obsO = {StallPcOut, StallIfIdOut, StallIdExOut, StallExMemOut, StallMemWbOut,
                 FlushIfIdOut, FlushIdExOut, RedirectOut};

  int tests  = 0;
  int failed = 0;
  int redirSeen = 0;

  // Model: which wait is in progress (0 none, 1 memory, 2 mul/div), pending redirect,
  // wait-cycle count, sticky error and stall-cycle count.
  int       mWait, mTo, mCnt;
  bit       mPend, mErr;
  logic [7:0] expO;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelClear();
    mWait = 0; mPend = 0; mTo = 0; mErr = 0; mCnt = 0;
  endtask

  // Expected strobes {pc,ifId,idEx,exMem,memWb,flushIfId,flushIdEx,redirect} for this cycle.
  task automatic computeExp();
    bit lu, memC, mdC;
    expO = '0;
    if (Rst) begin
      modelClear();
      return;
    end
    lu   = MemReadExIn && (RdAddrExIn != 0) &&
           ((Rs1ReadEnableIdIn && Rs1AddrIdIn == RdAddrExIn) ||
            (Rs2ReadEnableIdIn && Rs2AddrIdIn == RdAddrExIn));
    memC = DataReqMemIn && !DataReadyMemIn;
    mdC  = MulDivStartExIn && !MulDivDoneIn;
    if (mWait == 1)                  begin if (!DataReadyMemIn) expO = 8'b11111_000; end
    else if (mWait == 2)             begin if (!MulDivDoneIn)   expO = 8'b11110_000; end
    else if (memC)                   expO = 8'b11111_000;
    else if (mdC)                    expO = 8'b11110_000;
    else if (mPend || BranchTakenExIn) expO = 8'b00000_111;
    else if (lu)                     expO = 8'b11000_010;
  endtask

  // Advance the model across a clock edge using the inputs of the ending cycle.
  task automatic modelEdge();
    if (Rst) begin
      modelClear();
      return;
    end
    if (expO[7]) mCnt = (mCnt == CMAX) ? CMAX : mCnt + 1;
    if (mWait == 1) begin
      if (DataReadyMemIn) begin
        mWait = 0; mTo = 0;
      end else begin
        mTo = (mTo < TO) ? mTo + 1 : TO;
        if (TO != 0 && mTo == TO) mErr = 1;
      end
    end else if (mWait == 2) begin
      if (MulDivDoneIn) mWait = 0;
    end else if (DataReqMemIn && !DataReadyMemIn) begin
      mWait = 1;
      if (BranchTakenExIn) mPend = 1;
    end else if (MulDivStartExIn && !MulDivDoneIn) begin
      mWait = 2;
      if (BranchTakenExIn) mPend = 1;
    end else if (mPend) begin
      mPend = 0;
    end
  endtask

  // One clock cycle: inputs were driven at edge+1, compare at edge+4, then cross the edge.
  task automatic step(string tag);
    #3;
    computeExp();
    if (RedirectOut === 1'b1) redirSeen++;
    check({tag, ":strobes"}, 32'(obsO), 32'(expO));
    check({tag, ":cnt"}, 32'(StallCntOut), 32'(mCnt));
    check({tag, ":err"}, 32'(ErrorOut), 32'(mErr));
    @(posedge Clk);
    modelEdge();
    #1;
  endtask

  task automatic idle();
    Rst = 1'b0;
    Rs1AddrIdIn = '0; Rs2AddrIdIn = '0; RdAddrExIn = '0;
    Rs1ReadEnableIdIn = 1'b0; Rs2ReadEnableIdIn = 1'b0; MemReadExIn = 1'b0;
    MulDivStartExIn = 1'b0; MulDivDoneIn = 1'b0;
    DataReqMemIn = 1'b0; DataReadyMemIn = 1'b0; BranchTakenExIn = 1'b0;
  endtask

  task automatic doReset();
    idle();
    Rst = 1'b1;
    step("reset");
    Rst = 1'b0;
  endtask

  initial begin
    idle();
    Rst = 1'b1;
    modelClear();
    @(posedge Clk);
    #1;
    step("por");
    Rst = 1'b0;

    // Load-use on rs1.
    doReset();
    RdAddrExIn = 5'd5; MemReadExIn = 1'b1; Rs1AddrIdIn = 5'd5; Rs1ReadEnableIdIn = 1'b1;
    step("lu");
    idle();
    step("lu_after");
    check("lu_cnt", 32'(StallCntOut), 32'd1);

    // Load into x0 is no hazard.
    doReset();
    RdAddrExIn = 5'd0; MemReadExIn = 1'b1; Rs1AddrIdIn = 5'd0; Rs1ReadEnableIdIn = 1'b1;
    step("x0");
    idle();
    step("x0_after");
    check("x0_cnt", 32'(StallCntOut), 32'd0);

    // Memory wait with a branch on the first cycle: redirect once after the wait.
    doReset();
    redirSeen = 0;
    DataReqMemIn = 1'b1; BranchTakenExIn = 1'b1;
    step("mw0");
    idle();
    step("mw1");
    step("mw2");
    DataReadyMemIn = 1'b1;
    step("mw3");
    idle();
    step("mw4");
    step("mw5");
    check("mw_redirects", 32'(redirSeen), 32'd1);
    check("mw_cnt", 32'(StallCntOut), 32'd3);

    // Mul/div: start cycle 0, done cycle 4.
    doReset();
    MulDivStartExIn = 1'b1;
    step("md0");
    idle();
    step("md1");
    step("md2");
    step("md3");
    MulDivDoneIn = 1'b1;
    step("md4");
    idle();
    step("md5");
    check("md_cnt", 32'(StallCntOut), 32'd4);

    // Reset in the middle of a memory wait.
    doReset();
    DataReqMemIn = 1'b1;
    step("rw0");
    idle();
    step("rw1");
    Rst = 1'b1;
    step("rw2");
    idle();
    step("rw3");
    check("rw_cnt", 32'(StallCntOut), 32'd0);
    check("rw_run", 32'(StallPcOut), 32'd0);

    // Memory timeout: error after four wait cycles, sticky after ready.
    doReset();
    DataReqMemIn = 1'b1;
    step("to0");
    idle();
    step("to1");
    step("to2");
    step("to3");
    check("to_early", 32'(ErrorOut), 32'd0);
    step("to4");
    check("to_set", 32'(ErrorOut), 32'd1);
    step("to5");
    DataReadyMemIn = 1'b1;
    step("to6");
    idle();
    step("to7");
    check("to_sticky", 32'(ErrorOut), 32'd1);

    // Random traffic with small register ranges so dependencies are frequent.
    doReset();
    for (int i = 0; i < 600; i++) begin
      Rst               = ($urandom_range(0, 99) == 0);
      Rs1AddrIdIn       = 5'($urandom_range(0, 3));
      Rs2AddrIdIn       = 5'($urandom_range(0, 3));
      RdAddrExIn        = 5'($urandom_range(0, 3));
      Rs1ReadEnableIdIn = 1'($urandom_range(0, 1));
      Rs2ReadEnableIdIn = 1'($urandom_range(0, 1));
      MemReadExIn       = 1'($urandom_range(0, 1));
      MulDivStartExIn   = ($urandom_range(0, 9) == 0);
      MulDivDoneIn      = ($urandom_range(0, 9) < 3);
      DataReqMemIn      = ($urandom_range(0, 19) < 3);
      DataReadyMemIn    = ($urandom_range(0, 19) < 7);
      BranchTakenExIn   = ($urandom_range(0, 19) < 3);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
